// File: rtl/johnson_decoder.sv
// Decoder and lock tracker for a 4-bit Johnson (twisted-ring) counter stream.
// It flags illegal codes and out-of-sequence codes, and keeps a saturating error count.
module johnson_decoder #(
    parameter int LOCK_CNT   = 3,
    parameter int MISS_LIMIT = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       code_vld,
    input  logic [3:0] code_in,
    output logic       idx_vld,
    output logic [2:0] idx,
    output logic [7:0] onehot,
    output logic       illegal,
    output logic       seq_err,
    output logic       locked,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

    state_t     state_reg, state_next;
    logic [2:0] match_reg, match_next;
    logic [2:0] miss_reg, miss_next;
    logic [2:0] exp_reg, exp_next;

    logic       idx_vld_reg, idx_vld_next;
    logic [2:0] idx_reg, idx_next;
    logic [7:0] onehot_reg, onehot_next;
    logic       illegal_reg, illegal_next;
    logic       seq_err_reg, seq_err_next;
    logic       locked_reg, locked_next;
    logic [7:0] err_cnt_reg, err_cnt_next;

    logic       legal;
    logic [2:0] code_idx;
    logic [7:0] code_onehot;
    logic       in_seq;

    always_comb begin
        legal    = 1'b1;
        code_idx = 3'd0;
        case (code_in)
            4'b0000: code_idx = 3'd0;
            4'b0001: code_idx = 3'd1;
            4'b0011: code_idx = 3'd2;
            4'b0111: code_idx = 3'd3;
            4'b1111: code_idx = 3'd4;
            4'b1110: code_idx = 3'd5;
            4'b1100: code_idx = 3'd6;
            4'b1000: code_idx = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign code_onehot[gi] = (code_idx == 3'(gi));
        end
    endgenerate

    assign in_seq = (code_idx == exp_reg);

    always_comb begin
        state_next   = state_reg;
        match_next   = match_reg;
        miss_next    = miss_reg;
        exp_next     = exp_reg;
        idx_vld_next = 1'b0;
        idx_next     = idx_reg;
        onehot_next  = onehot_reg;
        illegal_next = 1'b0;
        seq_err_next = 1'b0;
        err_cnt_next = err_cnt_reg;

        if (code_vld) begin
            if (legal) begin
                idx_vld_next = 1'b1;
                idx_next     = code_idx;
                onehot_next  = code_onehot;
                exp_next     = code_idx + 3'd1;
            end else begin
                illegal_next = 1'b1;
            end

            case (state_reg)
                HUNT: begin
                    if (legal) begin
                        state_next = ACQ;
                        match_next = 3'd1;
                    end
                end
                ACQ: begin
                    if (!legal) begin
                        state_next = HUNT;
                        match_next = 3'd0;
                    end else if (in_seq) begin
                        match_next = match_reg + 3'd1;
                        if (match_next == 3'(LOCK_CNT)) begin
                            state_next = LOCKED;
                            miss_next  = 3'd0;
                        end
                    end else begin
                        match_next = 3'd1;
                    end
                end
                LOCKED: begin
                    if (legal && in_seq) begin
                        miss_next = 3'd0;
                    end else begin
                        // An illegal sample still advances the expected index so a
                        // single corrupted code does not desynchronise the check.
                        if (!legal)
                            exp_next = exp_reg + 3'd1;
                        else
                            seq_err_next = 1'b1;
                        miss_next = miss_reg + 3'd1;
                        if (miss_next == 3'(MISS_LIMIT)) begin
                            state_next = HUNT;
                            match_next = 3'd0;
                            miss_next  = 3'd0;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                    match_next = 3'd0;
                    miss_next  = 3'd0;
                end
            endcase

            if ((illegal_next || seq_err_next) && err_cnt_reg != 8'hFF)
                err_cnt_next = err_cnt_reg + 8'd1;
        end

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= HUNT;
            match_reg   <= 3'd0;
            miss_reg    <= 3'd0;
            exp_reg     <= 3'd0;
            idx_vld_reg <= 1'b0;
            idx_reg     <= 3'd0;
            onehot_reg  <= 8'd0;
            illegal_reg <= 1'b0;
            seq_err_reg <= 1'b0;
            locked_reg  <= 1'b0;
            err_cnt_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            match_reg   <= match_next;
            miss_reg    <= miss_next;
            exp_reg     <= exp_next;
            idx_vld_reg <= idx_vld_next;
            idx_reg     <= idx_next;
            onehot_reg  <= onehot_next;
            illegal_reg <= illegal_next;
            seq_err_reg <= seq_err_next;
            locked_reg  <= locked_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign idx_vld = idx_vld_reg;
    assign idx     = idx_reg;
    assign onehot  = onehot_reg;
    assign illegal = illegal_reg;
    assign seq_err = seq_err_reg;
    assign locked  = locked_reg;
    assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed bench for johnson_decoder: table of per-sample vectors plus hand-written
// sequences for reset, mid-lock clear and error-count saturation.
module tb_johnson_decoder;

    logic       clk = 1'b0;
    logic       clr;
    logic       code_vld;
    logic [3:0] code_in;
    logic       idx_vld;
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       illegal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    johnson_decoder #(.LOCK_CNT(3), .MISS_LIMIT(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .code_vld (code_vld),
        .code_in  (code_in),
        .idx_vld  (idx_vld),
        .idx      (idx),
        .onehot   (onehot),
        .illegal  (illegal),
        .seq_err  (seq_err),
        .locked   (locked),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [3:0] code;
        logic       e_vld;
        logic [2:0] e_idx;
        logic [7:0] e_oh;
        logic       e_ill;
        logic       e_se;
        logic       e_lk;
        logic [7:0] e_ec;
    } vec_t;

    vec_t vecs[28];

    function automatic vec_t mk(logic v, logic [3:0] c, logic ev, logic [2:0] ei,
                                logic [7:0] eo, logic il, logic se, logic lk, logic [7:0] ec);
        vec_t r;
        r.vld = v; r.code = c; r.e_vld = ev; r.e_idx = ei; r.e_oh = eo;
        r.e_ill = il; r.e_se = se; r.e_lk = lk; r.e_ec = ec;
        return r;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [2:0] ei,
                           input logic [7:0] eo, input logic il, input logic se,
                           input logic lk, input logic [7:0] ec);
        chk({tag, ".idx_vld"}, {7'd0, idx_vld}, {7'd0, ev});
        chk({tag, ".idx"},     {5'd0, idx},     {5'd0, ei});
        chk({tag, ".onehot"},  onehot,          eo);
        chk({tag, ".illegal"}, {7'd0, illegal}, {7'd0, il});
        chk({tag, ".seq_err"}, {7'd0, seq_err}, {7'd0, se});
        chk({tag, ".locked"},  {7'd0, locked},  {7'd0, lk});
        chk({tag, ".err_cnt"}, err_cnt,         ec);
    endtask

    // Drive one sample, then look at the registered outputs 1 time unit after the edge.
    task automatic apply(input logic v, input logic [3:0] c);
        code_vld = v;
        code_in  = c;
        @(posedge clk);
        #1;
        $display("sample vld=%0b code=%b -> idx_vld=%0b idx=%0d onehot=%h ill=%0b se=%0b lk=%0b ec=%0d",
                 v, c, idx_vld, idx, onehot, illegal, seq_err, locked, err_cnt);
    endtask

    initial begin
        // Lock, skip, wrap across gaps, seq_err loss, ACQ fallback, re-lock, illegal loss.
        vecs[0]  = mk(1, 4'b0000, 1, 0, 8'h01, 0, 0, 0, 0);
        vecs[1]  = mk(1, 4'b0001, 1, 1, 8'h02, 0, 0, 0, 0);
        vecs[2]  = mk(1, 4'b0011, 1, 2, 8'h04, 0, 0, 1, 0);
        vecs[3]  = mk(1, 4'b0111, 1, 3, 8'h08, 0, 0, 1, 0);
        vecs[4]  = mk(1, 4'b1100, 1, 6, 8'h40, 0, 1, 1, 1);
        vecs[5]  = mk(1, 4'b1000, 1, 7, 8'h80, 0, 0, 1, 1);
        vecs[6]  = mk(0, 4'b0101, 0, 7, 8'h80, 0, 0, 1, 1);
        vecs[7]  = mk(0, 4'b0000, 0, 7, 8'h80, 0, 0, 1, 1);
        vecs[8]  = mk(0, 4'b1111, 0, 7, 8'h80, 0, 0, 1, 1);
        vecs[9]  = mk(0, 4'b0011, 0, 7, 8'h80, 0, 0, 1, 1);
        vecs[10] = mk(1, 4'b0000, 1, 0, 8'h01, 0, 0, 1, 1);
        vecs[11] = mk(1, 4'b1111, 1, 4, 8'h10, 0, 1, 1, 2);
        vecs[12] = mk(1, 4'b0111, 1, 3, 8'h08, 0, 1, 0, 3);
        vecs[13] = mk(1, 4'b0101, 0, 3, 8'h08, 1, 0, 0, 4);
        vecs[14] = mk(1, 4'b1110, 1, 5, 8'h20, 0, 0, 0, 4);
        vecs[15] = mk(1, 4'b1100, 1, 6, 8'h40, 0, 0, 0, 4);
        vecs[16] = mk(1, 4'b1010, 0, 6, 8'h40, 1, 0, 0, 5);
        vecs[17] = mk(1, 4'b1000, 1, 7, 8'h80, 0, 0, 0, 5);
        vecs[18] = mk(1, 4'b0000, 1, 0, 8'h01, 0, 0, 0, 5);
        vecs[19] = mk(1, 4'b0001, 1, 1, 8'h02, 0, 0, 1, 5);
        vecs[20] = mk(1, 4'b0101, 0, 1, 8'h02, 1, 0, 1, 6);
        vecs[21] = mk(1, 4'b1010, 0, 1, 8'h02, 1, 0, 0, 7);
        vecs[22] = mk(1, 4'b0000, 1, 0, 8'h01, 0, 0, 0, 7);
        vecs[23] = mk(1, 4'b1111, 1, 4, 8'h10, 0, 0, 0, 7);
        vecs[24] = mk(1, 4'b1110, 1, 5, 8'h20, 0, 0, 0, 7);
        vecs[25] = mk(1, 4'b1100, 1, 6, 8'h40, 0, 0, 1, 7);
        vecs[26] = mk(1, 4'b1001, 0, 6, 8'h40, 1, 0, 1, 8);
        vecs[27] = mk(1, 4'b0000, 1, 0, 8'h01, 0, 0, 1, 8);

        // Reset, with code_vld held high to show it is ignored under clr.
        clr      = 1'b1;
        code_vld = 1'b1;
        code_in  = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 8'h00, 0, 0, 0, 0);
        clr      = 1'b0;
        code_vld = 1'b0;

        for (int i = 0; i < 28; i++) begin
            apply(vecs[i].vld, vecs[i].code);
            chk_all($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_idx, vecs[i].e_oh,
                    vecs[i].e_ill, vecs[i].e_se, vecs[i].e_lk, vecs[i].e_ec);
        end

        // Mid-lock clear: outputs drop without a clock edge, and lock history is gone.
        clr = 1'b1;
        #1;
        chk_all("midclr", 0, 0, 8'h00, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        apply(1, 4'b0001);
        chk_all("reacq1", 1, 1, 8'h02, 0, 0, 0, 0);
        apply(1, 4'b0011);
        chk_all("reacq2", 1, 2, 8'h04, 0, 0, 0, 0);
        apply(1, 4'b0111);
        chk_all("reacq3", 1, 3, 8'h08, 0, 0, 1, 0);

        // Saturation: lock is lost after two illegals, then the counter runs up to 255.
        for (int n = 1; n <= 300; n++) begin
            apply(1, 4'b0110);
            if (n == 2)   chk("sat.lost", {7'd0, locked}, 8'd0);
            if (n == 254) chk("sat.254", err_cnt, 8'd254);
            if (n == 255) chk("sat.255", err_cnt, 8'd255);
        end
        chk_all("sat.hold", 0, 3, 8'h08, 1, 0, 0, 8'd255);
        apply(0, 4'b0000);
        chk_all("sat.idle", 0, 3, 8'h08, 0, 0, 0, 8'd255);

        // Asynchronous clear in the middle of a clock period.
        #2;
        clr = 1'b1;
        #1;
        chk_all("asyncclr", 0, 0, 8'h00, 0, 0, 0, 0);
        clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
